fir_coef_sequencer: RTL and testbench

Owns the coefficient set of the 33-tap FIR filter in the signal_processing chain, so coefficients can change at run time without resetting the datapath. The host writes new coefficients into a shadow bank. On commit, the block copies the shadow bank into the active bank on a sample boundary. It then holds the filter in bypass until the delay line has refilled, and signals completion.

---
 rtl/fir_coef_sequencer.sv | 144 ++++++++++++++
 tb/tb_fir_coef_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_sequencer.sv
// rtl/fir_coef_sequencer.sv - shadow/active coefficient banks with sample-aligned swap and bypass flush
module fir_coef_sequencer #(
    parameter int N_TAPS        = 33,
    parameter int COEF_W        = 32,
    parameter int FLUSH_SAMPLES = 33,
    parameter int ADDR_W        = 6
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [ADDR_W-1:0]          cfg_addr,
    input  logic [COEF_W-1:0]          cfg_data,
    input  logic                       cfg_we,
    input  logic                       commit,
    input  logic                       abort,
    input  logic                       bypass_req,
    input  logic                       data_in_valid,
    output logic [N_TAPS*COEF_W-1:0]   coef_flat,
    output logic                       fir_bypass,
    output logic                       busy,
    output logic                       commit_done,
    output logic                       cfg_err,
    output logic                       coefs_valid
);

    localparam int CNT_W = (FLUSH_SAMPLES > 0) ? $clog2(FLUSH_SAMPLES + 1) : 1;
    localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(FLUSH_SAMPLES);

    typedef enum logic [1:0] {IDLE, ARMED, FLUSH, DONE} state_t;

    state_t            state, state_next;
    logic [COEF_W-1:0] shadow [N_TAPS];
    logic [COEF_W-1:0] active [N_TAPS];
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              int_bypass;
    logic              addr_ok;
    logic              write_ok;
    logic              bad_write;
    logic              bad_commit;
    logic              do_swap;
    logic              do_count;
    logic              do_release;

    assign cnt_inc    = cnt + CNT_W'(1);
    assign addr_ok    = ({1'b0, cfg_addr} < (ADDR_W + 1)'(N_TAPS));
    // Writes are independent of enable so the host can stage coefficients while the chain is paused.
    assign write_ok   = cfg_we && addr_ok && (state != ARMED);
    assign bad_write  = cfg_we && (!addr_ok || (state == ARMED));
    assign bad_commit = commit && enable && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_swap    = 1'b0;
        do_count   = 1'b0;
        do_release = 1'b0;
        case (state)
            IDLE: begin
                if (enable && commit) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                // abort takes priority over a coincident sample
                if (enable && abort) begin
                    state_next = IDLE;
                end else if (enable && data_in_valid) begin
                    do_swap    = 1'b1;
                    state_next = (FLUSH_SAMPLES == 0) ? DONE : FLUSH;
                end
            end
            FLUSH: begin
                if (enable && data_in_valid) begin
                    do_count = 1'b1;
                    if (cnt_inc == FLUSH_CNT) begin
                        do_release = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy        = (state == ARMED) || (state == FLUSH);
        commit_done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
            cnt         <= '0;
            int_bypass  <= 1'b1;
            cfg_err     <= 1'b0;
            coefs_valid <= 1'b0;
        end else begin
            if (write_ok) begin
                shadow[cfg_addr] <= cfg_data;
            end
            if (do_swap) begin
                for (int k = 0; k < N_TAPS; k++) begin
                    active[k] <= shadow[k];
                end
                // With no flush window the new set is live immediately.
                int_bypass <= (FLUSH_SAMPLES != 0);
                cnt        <= '0;
            end
            if (do_count) begin
                cnt <= cnt_inc;
            end
            if (do_release) begin
                int_bypass <= 1'b0;
            end
            cfg_err <= bad_write || bad_commit;
            if (state == DONE) begin
                coefs_valid <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_TAPS; g++) begin : g_flat
        assign coef_flat[g*COEF_W +: COEF_W] = active[g];
    end

    assign fir_bypass = bypass_req || int_bypass;

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// tb/tb_fir_coef_sequencer.sv - directed self-checking bench for fir_coef_sequencer
module tb_fir_coef_sequencer;

    localparam int N_TAPS = 33;
    localparam int COEF_W = 32;
    localparam int ADDR_W = 6;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     enable;
    logic [ADDR_W-1:0]        cfg_addr;
    logic [COEF_W-1:0]        cfg_data;
    logic                     cfg_we;
    logic                     commit;
    logic                     abort;
    logic                     bypass_req;
    logic                     data_in_valid;
    logic [N_TAPS*COEF_W-1:0] coef_flat, coef_flat1;
    logic                     fir_bypass, fir_bypass1;
    logic                     busy, busy1;
    logic                     commit_done, commit_done1;
    logic                     cfg_err, cfg_err1;
    logic                     coefs_valid, coefs_valid1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    fir_coef_sequencer #(.N_TAPS(N_TAPS), .COEF_W(COEF_W), .FLUSH_SAMPLES(33), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_we(cfg_we), .commit(commit), .abort(abort), .bypass_req(bypass_req),
        .data_in_valid(data_in_valid), .coef_flat(coef_flat), .fir_bypass(fir_bypass), .busy(busy),
        .commit_done(commit_done), .cfg_err(cfg_err), .coefs_valid(coefs_valid)
    );

    fir_coef_sequencer #(.N_TAPS(N_TAPS), .COEF_W(COEF_W), .FLUSH_SAMPLES(0), .ADDR_W(ADDR_W)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_we(cfg_we), .commit(commit), .abort(abort), .bypass_req(bypass_req),
        .data_in_valid(data_in_valid), .coef_flat(coef_flat1), .fir_bypass(fir_bypass1), .busy(busy1),
        .commit_done(commit_done1), .cfg_err(cfg_err1), .coefs_valid(coefs_valid1)
    );

    always @(posedge clk) if (commit_done) done_cnt++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [COEF_W-1:0] tap(input logic [N_TAPS*COEF_W-1:0] flat, input int k);
        return flat[k*COEF_W +: COEF_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [COEF_W-1:0] data);
        cfg_we = 1'b1; cfg_addr = ADDR_W'(addr); cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic pulse_valid();
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
    endtask

    int n;
    int snap;

    initial begin
        reset_n = 1'b0; enable = 1'b1; cfg_addr = '0; cfg_data = '0; cfg_we = 1'b0;
        commit = 1'b0; abort = 1'b0; bypass_req = 1'b0; data_in_valid = 1'b0;
        tick(); tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", commit_done, 0);
        check_eq("rst_err", cfg_err, 0);
        check_eq("rst_cvalid", coefs_valid, 0);
        check_eq("rst_bypass", fir_bypass, 1);
        check_eq("rst_flat_zero", (coef_flat == '0), 1);
        reset_n = 1'b1;
        tick();

        // Basic commit with a valid every 4th cycle
        for (int k = 0; k < N_TAPS; k++) wr(k, COEF_W'(k + 1));
        pulse_commit();
        check_eq("armed_busy", busy, 1);
        check_eq("armed_tap5_old", tap(coef_flat, 5), 0);
        tick(); tick(); tick();
        pulse_valid();
        check_eq("swap_tap5", tap(coef_flat, 5), 6);
        check_eq("swap_tap32", tap(coef_flat, 32), 33);
        check_eq("swap_bypass", fir_bypass, 1);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick(); tick(); tick();
            pulse_valid();
            n++;
            if (!fir_bypass) break;
        end
        check_eq("flush_valids", n, 33);
        check_eq("done_pulse", commit_done, 1);
        tick();
        check_eq("done_low", commit_done, 0);
        check_eq("cvalid_set", coefs_valid, 1);
        check_eq("idle_busy", busy, 0);
        check_eq("done_count", done_cnt, 1);
        bypass_req = 1'b1; #1;
        check_eq("bypass_req_pass", fir_bypass, 1);
        bypass_req = 1'b0; #1;
        check_eq("bypass_req_clear", fir_bypass, 0);

        // Rejected operations
        wr(40, 32'hBAD0);
        check_eq("err_addr", cfg_err, 1);
        tick();
        check_eq("err_addr_clear", cfg_err, 0);
        wr(3, 32'h100);
        check_eq("good_write_noerr", cfg_err, 0);
        pulse_commit();
        check_eq("idle_commit_noerr", cfg_err, 0);
        wr(5, 32'hDEAD);
        check_eq("err_armed_write", cfg_err, 1);
        pulse_valid();
        check_eq("swap2_tap3", tap(coef_flat, 3), 32'h100);
        check_eq("swap2_tap5", tap(coef_flat, 5), 6);
        pulse_commit();
        check_eq("err_flush_commit", cfg_err, 1);
        check_eq("flush_commit_busy", busy, 1);
        data_in_valid = 1'b1;
        for (int i = 0; i < 100 && !commit_done; i++) tick();
        data_in_valid = 1'b0;
        check_eq("done2", commit_done, 1);
        tick();

        // Commit then abort before any valid
        wr(3, 32'h200);
        snap = done_cnt;
        pulse_commit();
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check_eq("abort_idle", busy, 0);
        pulse_valid();
        check_eq("abort_tap3", tap(coef_flat, 3), 32'h100);
        check_eq("abort_no_done", done_cnt, snap);

        // Abort coincident with a valid
        pulse_commit();
        abort = 1'b1; data_in_valid = 1'b1; tick(); abort = 1'b0; data_in_valid = 1'b0;
        check_eq("abort_valid_tap3", tap(coef_flat, 3), 32'h100);
        check_eq("abort_valid_idle", busy, 0);

        // Enable dropped for 10 cycles mid-flush, valid every cycle
        pulse_commit();
        pulse_valid();
        check_eq("swap3_tap3", tap(coef_flat, 3), 32'h200);
        data_in_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            enable = (n >= 10 && n < 20) ? 1'b0 : 1'b1;
            tick();
            n++;
            if (n == 15) check_eq("frozen_busy", busy, 1);
            if (commit_done) break;
        end
        enable = 1'b1; data_in_valid = 1'b0;
        check_eq("delayed_done_cycles", n, 43);
        tick();

        // Reset mid-flush
        snap = done_cnt;
        pulse_commit();
        pulse_valid();
        for (int i = 0; i < 5; i++) pulse_valid();
        reset_n = 1'b0; tick();
        check_eq("mid_rst_flat", (coef_flat == '0), 1);
        check_eq("mid_rst_bypass", fir_bypass, 1);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_cvalid", coefs_valid, 0);
        check_eq("mid_rst_done", commit_done, 0);
        check_eq("mid_rst_err", cfg_err, 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) pulse_valid();
        check_eq("mid_rst_no_done", done_cnt, snap);
        check_eq("mid_rst_idle", busy, 0);

        // Zero-length flush instance
        wr(0, 32'h55);
        pulse_commit();
        check_eq("nf_armed_bypass", fir_bypass1, 1);
        pulse_valid();
        check_eq("nf_tap0", tap(coef_flat1, 0), 32'h55);
        check_eq("nf_done", commit_done1, 1);
        check_eq("nf_bypass_rel", fir_bypass1, 0);
        tick();
        check_eq("nf_done_low", commit_done1, 0);
        check_eq("nf_cvalid", coefs_valid1, 1);
        wr(0, 32'h66);
        pulse_commit();
        check_eq("nf2_armed_bypass", fir_bypass1, 0);
        pulse_valid();
        check_eq("nf2_tap0", tap(coef_flat1, 0), 32'h66);
        check_eq("nf2_swap_bypass", fir_bypass1, 0);
        check_eq("nf2_done", commit_done1, 1);
        tick();
        check_eq("nf2_after_bypass", fir_bypass1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
